// File: rtl/comb_result_buffer.sv
// Row buffer between the FM x WM x ADJ combination engine and the argmax stage.
// Optional per-row parity checking is enabled by defining COMB_BUF_PARITY_EN.
module comb_result_buffer #(
    parameter int ROWS           = 6,
    parameter int COLS           = 3,
    parameter int DATA_WIDTH     = 16,
    parameter int ROW_ADDR_WIDTH = 3
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic                                 wr_valid,
    input  logic [0:COLS-1][DATA_WIDTH-1:0]      wr_row_data,
    output logic                                 wr_ready,
    input  logic [ROW_ADDR_WIDTH-1:0]            read_row_arg,
    output logic [0:COLS-1][DATA_WIDTH-1:0]      fm_wm_adj_out,
    output logic                                 done_comb,
    input  logic                                 consumer_done,
    output logic                                 wr_overflow,
    output logic                                 parity_err
);

    typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

    localparam logic [ROW_ADDR_WIDTH-1:0] LAST_ROW = ROW_ADDR_WIDTH'(ROWS - 1);

    state_t                          state;
    logic [ROW_ADDR_WIDTH-1:0]       wr_ptr;
    logic [0:COLS-1][DATA_WIDTH-1:0] mem [ROWS];
    logic                            wr_en;
    logic                            addr_ok;

    // start overrides any same-cycle write, so the row offered with it is dropped
    assign wr_en = !start && (state == FILL) && wr_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            wr_overflow <= 1'b0;
            for (int i = 0; i < ROWS; i++) mem[i] <= '0;
        end else if (start) begin
            state       <= FILL;
            wr_ptr      <= '0;
            wr_overflow <= 1'b0;
        end else begin
            if (wr_valid && state != FILL) wr_overflow <= 1'b1;
            case (state)
                FILL: begin
                    if (wr_en) begin
                        mem[wr_ptr] <= wr_row_data;
                        if (wr_ptr == LAST_ROW) begin
                            wr_ptr <= '0;
                            state  <= FULL;
                        end else begin
                            wr_ptr <= wr_ptr + ROW_ADDR_WIDTH'(1);
                        end
                    end
                end
                FULL: if (consumer_done) state <= IDLE;
                default: ;
            endcase
        end
    end

    assign wr_ready  = (state == FILL);
    assign done_comb = (state == FULL);

    // Zero-latency read: the consumer samples in the cycle it drives the address
    assign addr_ok       = (state == FULL) && (read_row_arg <= LAST_ROW);
    assign fm_wm_adj_out = addr_ok ? mem[read_row_arg] : '0;

`ifdef COMB_BUF_PARITY_EN
    logic [ROWS-1:0] parity_mem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_mem <= '0;
        end else if (wr_en) begin
            parity_mem[wr_ptr] <= ^wr_row_data;
        end
    end

    assign parity_err = addr_ok ? ((^mem[read_row_arg]) ^ parity_mem[read_row_arg]) : 1'b0;
`else
    assign parity_err = 1'b0;
`endif

endmodule
